io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Shares the computer's 16-register I/O port bus (4-bit address, 8-bit bidirectional data, `io_oe`/`io_we` strobes) between several requesters, such as the CPU core and a debug/loader bridge. Each winning requester gets one fixed-length read or write transaction, sequenced by a small FSM. Arbitration is round-robin, with optional grant locking for back-to-back transfers. The block sits between the requesters and the top-level `io_*` pins of `computer`.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; index 0 is the CPU.
- `ADDR_W`, 4: I/O address width.
- `DATA_W`, 8: I/O data width.
- `HOLD_MAX`, 4: maximum consecutive transactions for one locked grant.

Ports:
- `clk`  in  1: system clock, single clock domain.
- `reset`  in  1: synchronous, active-low reset.
- `req`  in  NUM_REQ: transaction request, one bit per requester.
- `lock`  in  NUM_REQ: request to keep the grant after the current transfer.
- `we_in`  in  NUM_REQ: 1 = write, 0 = read.
- `addr_in`  in  NUM_REQ*ADDR_W: flattened addresses; requester i is at bits [i*ADDR_W +: ADDR_W].
- `wdata_in`  in  NUM_REQ*DATA_W: flattened write data.
- `gnt`  out  NUM_REQ: one-hot grant, held for the whole transaction.
- `ack`  out  NUM_REQ: one-cycle completion pulse to the granted requester.
- `rdata`  out  DATA_W: read data; valid in the `ack` cycle and held until the next read.
- `io_addr`  out  ADDR_W: I/O port address.
- `io_data`  inout  DATA_W: I/O data; high-Z except during a write.
- `io_oe`  out  1: bus transaction active.
- `io_we`  out  1: write strobe, only ever asserted together with `io_oe`.

## Operation
- FSM states: IDLE → SETUP → STROBE → DONE → (SETUP | IDLE).
- **IDLE**
  - If any `req` is high, pick a winner with the round-robin picker, starting at `last+1`.
  - Register `gnt`, and latch that requester's `we_in`, `addr_in` and `wdata_in`.
  - Go to SETUP.
- **SETUP**
  - Drive `io_addr` = latched address and `io_oe`=1.
  - On a write, also drive `io_data` = latched data; `io_we` stays 0.
- **STROBE**
  - On a write, `io_we`=1 and the data is still driven.
  - On a read, `io_data` is high-Z and `rdata` captures `io_data` at the end of this cycle.
- **DONE**
  - `ack[g]`=1 for one cycle; `io_oe`, `io_we`=0; `io_data` high-Z.
  - If `lock[g]` and `req[g]` are high and `hold_cnt < HOLD_MAX-1`: increment `hold_cnt`, re-latch the inputs and go to SETUP with `gnt` unchanged.
  - Otherwise: `last`←g, `hold_cnt`←0, `gnt`←0, go to IDLE.
- Request and operand inputs are sampled only at the latch points. Changing or dropping `req` mid-transaction has no effect; the transaction completes and still acks.
- `ack` is only ever asserted to the currently granted index.
- Reset (`reset`=0 at a rising edge), even mid-transaction:
  - State = IDLE, `gnt`=0, `ack`=0, `rdata`=0, `io_addr`=0, `io_oe`=0, `io_we`=0, `io_data` high-Z.
  - `last`=NUM_REQ-1, so requester 0 wins first; `hold_cnt`=0.
  - A partially performed write is abandoned and no `ack` is issued.

## Timing
- `req` sampled at edge N → `gnt` and SETUP from N+1 → STROBE from N+2 → `ack` in the N+3 cycle.
- An unlocked transaction occupies the bus for 4 cycles including IDLE. A locked follow-on transaction costs 3 cycles.
- `io_addr` is stable from SETUP through STROBE, so the address sets up one full cycle before `io_we`.
- Write data is held for the whole of SETUP and STROBE.
- `io_we` is high for exactly one cycle per write.
- All outputs are registered; there is no combinational path from `req` to the `io_*` pins.

## Configuration
- `IO_ARB_PRIO_EN` defined:
  - Requester 0 has fixed highest priority in IDLE; the rest rotate round-robin among themselves.
  - A locked grant held by another requester is cut short at DONE whenever `req[0]` is high.
- `IO_ARB_PRIO_EN` undefined: pure round-robin over all requesters, and `lock` is honoured up to `HOLD_MAX`.

## Structure
- Package `io_arb_pkg`:
  - state enum `io_arb_state_t` (IDLE, SETUP, STROBE, DONE);
  - default `IO_ADDR_W`=4 and `IO_DATA_W`=8 constants.
- Sub-module `io_arb_rr_pick`: combinational round-robin picker. Inputs `req` and `last`; outputs one-hot `win` and index `win_idx`. It is instantiated once.

## Test plan
- Single write: CPU `req[0]`, `we`=1, addr=4'h3, data=8'hA5 → `io_addr`=3 for 2 cycles, `io_we`=1 for 1 cycle with `io_data`=A5, `ack[0]` at N+3.
- Single read: requester 1 reads addr 4'hC while the bench drives `io_data`=8'h5A → `io_we`=0 throughout, `rdata`=5A in the `ack[1]` cycle, `io_data` never driven by the DUT.
- Contention: `req`=2'b11 held high continuously → grants alternate 0,1,0,1. Each `ack` is exactly 4 cycles apart, and `gnt` is never multi-hot.
- Lock: `req[1]` and `lock[1]` held, HOLD_MAX=4, `req[0]` also high → 4 back-to-back requester-1 transfers, then requester 0 is granted. With `IO_ARB_PRIO_EN`, requester 1 gets only 1 transfer.
- Reset in STROBE of a write → next cycle `io_oe`=`io_we`=0, `io_data`=Z, no `ack`. The first grant after reset goes to requester 0.
- Request dropped in SETUP → transaction still completes and `ack` still fires.

Source files
------------

// File: rtl/io_arb_pkg.sv
// io_arb_pkg: shared types and default widths for the I/O bus arbiter.
// State enum and default I/O address/data widths.
package io_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    DONE
  } io_arb_state_t;

  localparam int IO_ADDR_W = 4;
  localparam int IO_DATA_W = 8;

endpackage

// File: rtl/io_arb_rr_pick.sv
// io_arb_rr_pick: combinational round-robin picker, search starts at last+1.
// IO_ARB_PRIO_EN gives index 0 fixed priority; the rest rotate.
module io_arb_rr_pick
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx
);

`ifdef IO_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic [IDX_W:0]   s;
  logic [IDX_W-1:0] j;
  logic             found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    s       = '0;
    j       = '0;
    found   = 1'b0;
    if (PRIO && req[0]) begin
      win[0] = 1'b1;
      found  = 1'b1;
    end
    for (int k = 1; k <= NUM_REQ; k++) begin
      s = {1'b0, last} + (IDX_W+1)'(k);
      if (s >= (IDX_W+1)'(NUM_REQ))
        s = s - (IDX_W+1)'(NUM_REQ);
      j = s[IDX_W-1:0];
      if (!found && req[j] && !(PRIO && j == '0)) begin
        win[j]  = 1'b1;
        win_idx = j;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the 16-port I/O bus between requesters.
// Option IO_ARB_PRIO_EN: requester 0 has priority and cuts locks short.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = IO_ADDR_W,
  parameter int DATA_W   = IO_DATA_W,
  parameter int HOLD_MAX = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we_in,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         io_addr,
  inout  wire  [DATA_W-1:0]         io_data,
  output logic                      io_oe,
  output logic                      io_we
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(HOLD_MAX) + 1;

  io_arb_state_t      state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   g_idx;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   sel;
  logic [NUM_REQ-1:0] win;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [DATA_W-1:0]  wdata_q;
  logic               we_q;
  logic               drv;
  logic               cut;
  logic               keep;

  io_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req),
    .last    (last),
    .win     (win),
    .win_idx (win_idx)
  );

`ifdef IO_ARB_PRIO_EN
  assign cut = req[0] && (g_idx != '0);
`else
  assign cut = 1'b0;
`endif

  assign keep = lock[g_idx] && req[g_idx] && !cut &&
                (hold_cnt < HOLD_W'(HOLD_MAX - 1));

  // Operands come from the new winner in IDLE, the holder in DONE.
  assign sel = (state == IDLE) ? win_idx : g_idx;

  assign io_data = drv ? wdata_q : 'z;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      gnt      <= '0;
      ack      <= '0;
      rdata    <= '0;
      io_addr  <= '0;
      io_oe    <= 1'b0;
      io_we    <= 1'b0;
      drv      <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      g_idx    <= '0;
      hold_cnt <= '0;
      last     <= IDX_W'(NUM_REQ - 1);
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= win;
            g_idx   <= win_idx;
            we_q    <= we_in[sel];
            io_addr <= addr_in[sel*ADDR_W +: ADDR_W];
            wdata_q <= wdata_in[sel*DATA_W +: DATA_W];
            drv     <= we_in[sel];
            io_oe   <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          io_we <= we_q;
          state <= STROBE;
        end
        STROBE: begin
          if (!we_q)
            rdata <= io_data;
          ack   <= gnt;
          io_oe <= 1'b0;
          io_we <= 1'b0;
          drv   <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          if (keep) begin
            hold_cnt <= hold_cnt + 1'b1;
            we_q     <= we_in[sel];
            io_addr  <= addr_in[sel*ADDR_W +: ADDR_W];
            wdata_q  <= wdata_in[sel*DATA_W +: DATA_W];
            drv      <= we_in[sel];
            io_oe    <= 1'b1;
            state    <= SETUP;
          end else begin
            last     <= g_idx;
            hold_cnt <= '0;
            gnt      <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed and random checks against a transaction model.
`timescale 1ns/1ps
module tb_io_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int HM = 4;

`ifdef IO_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  lock = '0;
  logic [N-1:0]  we_in = '0;
  logic [N*AW-1:0] addr_in = '0;
  logic [N*DW-1:0] wdata_in = '0;
  logic [N-1:0]  gnt;
  logic [N-1:0]  ack;
  logic [DW-1:0] rdata;
  logic [AW-1:0] io_addr;
  wire  [DW-1:0] io_data;
  logic          io_oe;
  logic          io_we;

  logic          tb_drv = 1'b1;
  logic [DW-1:0] tb_val = 8'h3C;

  assign io_data = tb_drv ? tb_val : 'z;

  int checks = 0;
  int errors = 0;

  int            m_last = N - 1;
  int            m_hold = 0;
  logic [DW-1:0] m_rdata = '0;
  int            w;
  int            nx;
  bit            l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_data;

  io_bus_arbiter #(
    .NUM_REQ  (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .HOLD_MAX (HM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .lock     (lock),
    .we_in    (we_in),
    .addr_in  (addr_in),
    .wdata_in (wdata_in),
    .gnt      (gnt),
    .ack      (ack),
    .rdata    (rdata),
    .io_addr  (io_addr),
    .io_data  (io_data),
    .io_oe    (io_oe),
    .io_we    (io_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Bench drives the bus whenever the DUT must not.
  task automatic tick(input bit dut_writes);
    @(posedge clk);
    #1 tb_drv = !dut_writes;
    #1;
  endtask

  function automatic int model_pick(input logic [N-1:0] r);
    if (PRIO && r[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int j = (m_last + k) % N;
      if (PRIO && j == 0) continue;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic latch(input int idx);
    l_we   = we_in[idx];
    l_addr = addr_in[idx*AW +: AW];
    l_data = wdata_in[idx*DW +: DW];
    tb_val = ~l_data;
  endtask

  task automatic rnd_inputs();
    req      = N'($urandom);
    lock     = N'($urandom);
    we_in    = N'($urandom);
    addr_in  = (N*AW)'($urandom);
    wdata_in = (N*DW)'($urandom);
  endtask

  task automatic phase(input bit mid_en, input logic [N-1:0] mid_req);
    tick(l_we);
    chk("setup_gnt", 32'(gnt), 32'(1 << w));
    chk("setup_oe", 32'(io_oe), 32'(1));
    chk("setup_we", 32'(io_we), 32'(0));
    chk("setup_addr", 32'(io_addr), 32'(l_addr));
    chk("setup_ack", 32'(ack), 32'(0));
    chk("setup_data", 32'(io_data), 32'(l_we ? l_data : tb_val));
    chk("setup_rdata", 32'(rdata), 32'(m_rdata));
    if (mid_en) req = mid_req;
    tick(l_we);
    chk("strobe_gnt", 32'(gnt), 32'(1 << w));
    chk("strobe_oe", 32'(io_oe), 32'(1));
    chk("strobe_we", 32'(io_we), 32'(l_we));
    chk("strobe_addr", 32'(io_addr), 32'(l_addr));
    chk("strobe_ack", 32'(ack), 32'(0));
    chk("strobe_data", 32'(io_data), 32'(l_we ? l_data : tb_val));
    if (!l_we) m_rdata = tb_val;
    tick(1'b0);
    chk("done_ack", 32'(ack), 32'(1 << w));
    chk("done_gnt", 32'(gnt), 32'(1 << w));
    chk("done_oe", 32'(io_oe), 32'(0));
    chk("done_we", 32'(io_we), 32'(0));
    chk("done_data", 32'(io_data), 32'(tb_val));
    chk("done_rdata", 32'(rdata), 32'(m_rdata));
  endtask

  task automatic serve(input bit rnd, input bit mid_en,
                       input logic [N-1:0] mid_req, output int n);
    n = 0;
    w = model_pick(req);
    if (w < 0) begin
      tick(1'b0);
      chk("idle_gnt", 32'(gnt), 32'(0));
      chk("idle_oe", 32'(io_oe), 32'(0));
      chk("idle_ack", 32'(ack), 32'(0));
      return;
    end
    latch(w);
    forever begin
      phase(mid_en, mid_req);
      mid_en = 1'b0;
      n++;
      if (rnd) rnd_inputs();
      if (lock[w] && req[w] && m_hold < HM - 1 &&
          !(PRIO && req[0] && w != 0)) begin
        m_hold++;
        latch(w);
      end else begin
        m_last = w;
        m_hold = 0;
        tick(1'b0);
        chk("end_gnt", 32'(gnt), 32'(0));
        chk("end_oe", 32'(io_oe), 32'(0));
        chk("end_we", 32'(io_we), 32'(0));
        chk("end_ack", 32'(ack), 32'(0));
        chk("end_data", 32'(io_data), 32'(tb_val));
        break;
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_addr", 32'(io_addr), 32'(0));
    chk("rst_oe", 32'(io_oe), 32'(0));
    chk("rst_we", 32'(io_we), 32'(0));
    chk("rst_data", 32'(io_data), 32'(tb_val));
    reset = 1'b1;

    req = 2'b01; we_in = 2'b01;
    addr_in = 8'h03; wdata_in = 16'h00A5;
    serve(1'b0, 1'b0, '0, nx);
    chk("wr_winner", 32'(w), 32'(0));

    req = 2'b10; we_in = 2'b00;
    addr_in = 8'hC0; wdata_in = 16'hA500;
    serve(1'b0, 1'b0, '0, nx);
    chk("rd_winner", 32'(w), 32'(1));
    chk("rd_rdata", 32'(rdata), 32'(8'h5A));

    req = 2'b11; we_in = 2'b01;
    addr_in = 8'h96; wdata_in = 16'h1122;
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, 1'b0, '0, nx);
      chk("cont_order", 32'(w), 32'(i % 2));
    end

    req = 2'b10; lock = 2'b10; we_in = 2'b10;
    addr_in = 8'h70; wdata_in = 16'h6600;
    serve(1'b0, 1'b1, 2'b11, nx);
    chk("lock_xfers", 32'(nx), 32'(PRIO ? 1 : 4));
    lock = 2'b00;
    serve(1'b0, 1'b0, '0, nx);
    chk("lock_next", 32'(w), 32'(0));

    req = 2'b10; we_in = 2'b10;
    addr_in = 8'hE0; wdata_in = 16'h3C00;
    serve(1'b0, 1'b1, 2'b00, nx);
    chk("drop_xfers", 32'(nx), 32'(1));

    req = 2'b01; we_in = 2'b01;
    addr_in = 8'h05; wdata_in = 16'h00C3;
    tb_val = 8'h3C;
    tick(1'b1);
    chk("rs_setup_oe", 32'(io_oe), 32'(1));
    tick(1'b1);
    chk("rs_strobe_we", 32'(io_we), 32'(1));
    reset = 1'b0;
    req = 2'b11;
    tick(1'b0);
    chk("rs_oe", 32'(io_oe), 32'(0));
    chk("rs_we", 32'(io_we), 32'(0));
    chk("rs_ack", 32'(ack), 32'(0));
    chk("rs_gnt", 32'(gnt), 32'(0));
    chk("rs_data", 32'(io_data), 32'(tb_val));
    chk("rs_rdata", 32'(rdata), 32'(0));
    reset = 1'b1;
    m_last = N - 1; m_hold = 0; m_rdata = '0;
    serve(1'b0, 1'b0, '0, nx);
    chk("rs_first", 32'(w), 32'(0));

    for (int i = 0; i < 60; i++) begin
      rnd_inputs();
      serve(1'b1, 1'b0, '0, nx);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end

endmodule
